dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 99 +++++++++
 tb/tb_dmem_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port data RAM: the pipeline (CPU) wins by default,
// the loader/debug port (EXT) is force-granted after STARVE_LIM consecutive denials.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_rvalid,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_do
);

  localparam logic [2:0] LIM = 3'(STARVE_LIM);

  // Index 0 is the CPU, index 1 is EXT.
  logic [1:0] we_vec;
  logic [1:0] gnt;
  logic [1:0] own_reg;
  logic [1:0] own_next;
  logic [2:0] wait_cnt_reg;
  logic [2:0] wait_cnt_next;
  logic       force_ext;

  assign we_vec = {ext_we, cpu_we};

  always_comb begin
    force_ext     = cpu_req & ext_req & (wait_cnt_reg == LIM);
    gnt           = 2'b00;
    wait_cnt_next = 3'd0;
    if (cpu_req && !force_ext) begin
      gnt[0] = 1'b1;
    end else if (ext_req) begin
      gnt[1] = 1'b1;
    end
    // Only a denied EXT request keeps counting; everything else clears.
    if (ext_req && !gnt[1] && (wait_cnt_reg < LIM)) begin
      wait_cnt_next = wait_cnt_reg + 3'd1;
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    if (gnt[0]) begin
      ram_we   = cpu_we;
      ram_addr = cpu_addr;
      ram_di   = cpu_wdata;
    end else if (gnt[1]) begin
      ram_we   = ext_we;
      ram_addr = ext_addr;
      ram_di   = ext_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_own
      assign own_next[gi] = gnt[gi] & ~we_vec[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!clrn) begin
      own_reg      <= 2'b00;
      wait_cnt_reg <= 3'd0;
    end else begin
      own_reg      <= own_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign cpu_stall = cpu_req & ~gnt[0];
  assign ext_gnt   = gnt[1];

  // Gating with clrn also hides a pending rvalid while reset is held.
  assign cpu_rvalid = own_reg[0] & clrn;
  assign ext_rvalid = own_reg[1] & clrn;
  assign cpu_rdata  = cpu_rvalid ? ram_do : '0;
  assign ext_rdata  = ext_rvalid ? ram_do : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt;
  logic [31:0] ext_rdata;
  logic        ext_rvalid;
  logic        ram_we;
  logic [31:0] ram_addr, ram_di, ram_do;

  logic [31:0] mem [0:255];
  int errors = 0;
  int checks = 0;
  logic prev_cpu, prev_ext, exp_ext;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIM(4)) dut (
    .clk(clk), .clrn(clrn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[7:0]] <= ram_di;
    ram_do <= mem[ram_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h04] = 32'h44444444;
    mem[8'h08] = 32'h88888888;
    clrn = 0;
    idle_inputs();

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
    chk("rst_ext_rvalid", {31'b0, ext_rvalid}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ext_rdata", ext_rdata, 0);
    chk("rst_wait_cnt", {29'b0, dut.wait_cnt_reg}, 0);
    next_cycle();
    clrn = 1;
    @(negedge clk);
    chk("post_rst_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
    chk("post_rst_ext_rvalid", {31'b0, ext_rvalid}, 0);
    $display("txn reset released");

    // CPU-only read of 0x10
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    chk("cpurd_ram_addr", ram_addr, 32'h10);
    chk("cpurd_ram_we", {31'b0, ram_we}, 0);
    chk("cpurd_stall", {31'b0, cpu_stall}, 0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("cpurd_rvalid", {31'b0, cpu_rvalid}, 1);
    chk("cpurd_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("cpurd_ext_rvalid", {31'b0, ext_rvalid}, 0);
    $display("txn cpu read addr=10 data=%h", cpu_rdata);

    // EXT-only write of 0x12345678 to 0x20
    next_cycle();
    ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'h12345678;
    @(negedge clk);
    chk("extwr_gnt", {31'b0, ext_gnt}, 1);
    chk("extwr_ram_we", {31'b0, ram_we}, 1);
    chk("extwr_ram_addr", ram_addr, 32'h20);
    chk("extwr_ram_di", ram_di, 32'h12345678);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("extwr_no_ext_rvalid", {31'b0, ext_rvalid}, 0);
    chk("extwr_no_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
    chk("extwr_mem", mem[8'h20], 32'h12345678);
    $display("txn ext write addr=20 data=12345678");

    // Both held continuously: EXT wins every 5th cycle
    prev_cpu = 0; prev_ext = 0;
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
    ext_req = 1; ext_we = 0; ext_addr = 32'h8;
    for (int k = 0; k < 10; k++) begin
      exp_ext = (k % 5 == 4);
      @(negedge clk);
      chk($sformatf("starve_stall_%0d", k), {31'b0, cpu_stall}, {31'b0, exp_ext});
      chk($sformatf("starve_gnt_%0d", k), {31'b0, ext_gnt}, {31'b0, exp_ext});
      chk($sformatf("starve_cpu_rvalid_%0d", k), {31'b0, cpu_rvalid}, {31'b0, prev_cpu});
      chk($sformatf("starve_ext_rvalid_%0d", k), {31'b0, ext_rvalid}, {31'b0, prev_ext});
      chk($sformatf("starve_cpu_rdata_%0d", k), cpu_rdata, prev_cpu ? 32'h44444444 : 32'h0);
      chk($sformatf("starve_ext_rdata_%0d", k), ext_rdata, prev_ext ? 32'h88888888 : 32'h0);
      $display("txn both-req cycle=%0d ext_gnt=%0d cpu_stall=%0d", k, ext_gnt, cpu_stall);
      prev_cpu = !exp_ext;
      prev_ext = exp_ext;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("starve_tail_ext_rvalid", {31'b0, ext_rvalid}, 1);
    chk("starve_tail_ext_rdata", ext_rdata, 32'h88888888);
    chk("starve_tail_cpu_rvalid", {31'b0, cpu_rvalid}, 0);

    // Alternating CPU read 0x4 / EXT read 0x8
    prev_cpu = 0; prev_ext = 0;
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      idle_inputs();
      if (k % 2 == 0) begin
        cpu_req = 1; cpu_addr = 32'h4;
      end else begin
        ext_req = 1; ext_addr = 32'h8;
      end
      @(negedge clk);
      chk($sformatf("alt_ram_addr_%0d", k), ram_addr, (k % 2 == 0) ? 32'h4 : 32'h8);
      chk($sformatf("alt_ext_gnt_%0d", k), {31'b0, ext_gnt}, (k % 2 == 0) ? 32'h0 : 32'h1);
      chk($sformatf("alt_cpu_rvalid_%0d", k), {31'b0, cpu_rvalid}, {31'b0, prev_cpu});
      chk($sformatf("alt_ext_rvalid_%0d", k), {31'b0, ext_rvalid}, {31'b0, prev_ext});
      chk($sformatf("alt_cpu_rdata_%0d", k), cpu_rdata, prev_cpu ? 32'h44444444 : 32'h0);
      chk($sformatf("alt_ext_rdata_%0d", k), ext_rdata, prev_ext ? 32'h88888888 : 32'h0);
      chk($sformatf("alt_excl_%0d", k), {31'b0, cpu_rvalid & ext_rvalid}, 0);
      $display("txn alternate cycle=%0d cpu_rvalid=%0d ext_rvalid=%0d", k, cpu_rvalid, ext_rvalid);
      prev_cpu = (k % 2 == 0);
      prev_ext = (k % 2 == 1);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("alt_tail_ext_rvalid", {31'b0, ext_rvalid}, 1);
    chk("alt_tail_ext_rdata", ext_rdata, 32'h88888888);
    chk("alt_tail_cpu_rvalid", {31'b0, cpu_rvalid}, 0);

    // CPU read granted while wait_cnt is counting, reset on the following edge
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    ext_req = 1; ext_we = 0; ext_addr = 32'h8;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rstrd_stall", {31'b0, cpu_stall}, 0);
    chk("rstrd_wait_before", {29'b0, dut.wait_cnt_reg}, 2);
    clrn = 0;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("rstrd_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
    chk("rstrd_cpu_rdata", cpu_rdata, 0);
    chk("rstrd_wait_cnt", {29'b0, dut.wait_cnt_reg}, 0);
    next_cycle();
    clrn = 1;
    @(negedge clk);
    chk("rstrd_after_cpu_rvalid", {31'b0, cpu_rvalid}, 0);
    $display("txn read then reset: cpu_rvalid=%0d", cpu_rvalid);

    // Ten idle cycles
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      @(negedge clk);
      chk($sformatf("idle_ram_we_%0d", k), {31'b0, ram_we}, 0);
      chk($sformatf("idle_ram_addr_%0d", k), ram_addr, 0);
      chk($sformatf("idle_cpu_rvalid_%0d", k), {31'b0, cpu_rvalid}, 0);
      chk($sformatf("idle_ext_rvalid_%0d", k), {31'b0, ext_rvalid}, 0);
      chk($sformatf("idle_stall_%0d", k), {31'b0, cpu_stall}, 0);
      chk($sformatf("idle_gnt_%0d", k), {31'b0, ext_gnt}, 0);
    end
    $display("txn idle 10 cycles");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
